// File: rtl/tile_turn_ctrl_pkg.sv
// Shared game definitions: turn-sequencer states, board defaults and the
// one-hot-to-index helper also used by the board store.
package tile_turn_ctrl_pkg;

    localparam int NUM_TILES_DEF = 10;
    localparam int VAL_W_DEF     = 4;
    localparam int MOVE_W_DEF    = 8;
    localparam int MAX_TILES     = 32;

    typedef enum logic [3:0] {
        IDLE, WAIT1, READ1, CAP1, WAIT2, READ2, CAP2, CMP, SHOW, DONE
    } state_e;

    // Index of the highest set bit; callers guarantee the input is one-hot.
    function automatic int onehot_to_idx(input logic [MAX_TILES-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_TILES; i++)
            if (oh[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/tile_turn_ctrl_if.sv
// Board-store read bus: the turn sequencer is the master, the store answers
// with the tile value one cycle after the strobe.
interface tile_turn_ctrl_if #(
    parameter int NUM_TILES = tile_turn_ctrl_pkg::NUM_TILES_DEF,
    parameter int VAL_W     = tile_turn_ctrl_pkg::VAL_W_DEF
);
    localparam int IDX_W = $clog2(NUM_TILES);

    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [VAL_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input  rd_data);
    modport slave  (input  rd_en, input  rd_addr, output rd_data);
endinterface

// File: rtl/tile_turn_ctrl_show_timer.sv
// Loadable down-counter that holds a mismatched pair face-up; done while zero.
module show_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          done
);
    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/tile_turn_ctrl.sv
// Turn sequencer: takes two tile picks, reads their values from the board
// store, compares them and tracks matched tiles and the move count.
module tile_turn_ctrl
    import tile_turn_ctrl_pkg::*;
#(
    parameter int NUM_TILES   = NUM_TILES_DEF,
    parameter int VAL_W       = VAL_W_DEF,
    parameter int MOVE_W      = MOVE_W_DEF,
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic                 CLOCK_50,
    input  logic                 userquit_n,
    input  logic                 start,
    input  logic                 select1,
    input  logic                 select2,
    input  logic [NUM_TILES-1:0] sw,
    tile_turn_ctrl_if.master     rd_bus,
    output logic [NUM_TILES-1:0] revealed,
    output logic [NUM_TILES-1:0] matched,
    output logic [MOVE_W-1:0]    moves,
    output logic                 bad_sel,
    output logic                 busy,
    output logic                 game_over
);
    localparam int IDX_W = $clog2(NUM_TILES);
    localparam int TW    = $clog2(SHOW_CYCLES + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx1_q, idx1_d, idx2_q, idx2_d;
    logic [VAL_W-1:0]     val1_q, val1_d, val2_q, val2_d;
    logic [NUM_TILES-1:0] revealed_q, revealed_d, matched_q, matched_d;
    logic [MOVE_W-1:0]    moves_q, moves_d;
    logic                 bad_q, bad_d, sel1_q, sel2_q;
    logic                 tmr_load, tmr_done;

    logic                 edge1, edge2, pick_ok;
    logic [IDX_W-1:0]     sw_idx;
    logic [NUM_TILES-1:0] mask1, mask2, pair;

    assign edge1   = select1 & ~sel1_q;
    assign edge2   = select2 & ~sel2_q;
    assign sw_idx  = IDX_W'(onehot_to_idx(MAX_TILES'(sw)));
    assign pick_ok = $onehot(sw) && ((sw & matched_q) == '0);
    assign mask1   = NUM_TILES'(1) << idx1_q;
    assign mask2   = NUM_TILES'(1) << idx2_q;
    assign pair    = mask1 | mask2;

    always_comb begin
        state_d    = state_q;
        idx1_d     = idx1_q;
        idx2_d     = idx2_q;
        val1_d     = val1_q;
        val2_d     = val2_q;
        revealed_d = revealed_q;
        matched_d  = matched_q;
        moves_d    = moves_q;
        bad_d      = 1'b0;
        tmr_load   = 1'b0;
        // start wins from any state and abandons the turn in progress
        if (start) begin
            state_d    = WAIT1;
            revealed_d = '0;
            matched_d  = '0;
            moves_d    = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: ;
                WAIT1: if (edge1) begin
                    if (pick_ok) begin
                        idx1_d  = sw_idx;
                        state_d = READ1;
                    end else bad_d = 1'b1;
                end
                READ1: state_d = CAP1;
                CAP1: begin
                    val1_d     = rd_bus.rd_data;
                    revealed_d = revealed_q | mask1;
                    state_d    = WAIT2;
                end
                WAIT2: if (edge2) begin
                    if (pick_ok && sw_idx != idx1_q) begin
                        idx2_d  = sw_idx;
                        state_d = READ2;
                    end else bad_d = 1'b1;
                end
                READ2: state_d = CAP2;
                CAP2: begin
                    val2_d     = rd_bus.rd_data;
                    revealed_d = revealed_q | mask2;
                    state_d    = CMP;
                end
                CMP: begin
                    if (moves_q != '1) moves_d = moves_q + 1'b1;
                    if (val1_q == val2_q) begin
                        matched_d  = matched_q | pair;
                        revealed_d = revealed_q & ~pair;
                        state_d    = (&(matched_q | pair)) ? DONE : WAIT1;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = SHOW;
                    end
                end
                SHOW: if (tmr_done) begin
                    revealed_d = revealed_q & ~pair;
                    state_d    = WAIT1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge userquit_n) begin
        if (!userquit_n) begin
            state_q    <= IDLE;
            idx1_q     <= '0;
            idx2_q     <= '0;
            val1_q     <= '0;
            val2_q     <= '0;
            revealed_q <= '0;
            matched_q  <= '0;
            moves_q    <= '0;
            bad_q      <= 1'b0;
            sel1_q     <= 1'b0;
            sel2_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx1_q     <= idx1_d;
            idx2_q     <= idx2_d;
            val1_q     <= val1_d;
            val2_q     <= val2_d;
            revealed_q <= revealed_d;
            matched_q  <= matched_d;
            moves_q    <= moves_d;
            bad_q      <= bad_d;
            sel1_q     <= select1;
            sel2_q     <= select2;
        end
    end

    show_timer #(.TW(TW)) u_show_timer (
        .clk      (CLOCK_50),
        .rst_n    (userquit_n),
        .load     (tmr_load),
        .load_val (TW'(SHOW_CYCLES - 1)),
        .en       (state_q == SHOW),
        .done     (tmr_done)
    );

    assign rd_bus.rd_en   = (state_q == READ1) || (state_q == READ2);
    assign rd_bus.rd_addr = (state_q == READ2) ? idx2_q : idx1_q;
    assign revealed       = revealed_q;
    assign matched        = matched_q;
    assign moves          = moves_q;
    assign bad_sel        = bad_q;
    assign busy           = !(state_q inside {IDLE, WAIT1, WAIT2, DONE});
    assign game_over      = (state_q == DONE);
endmodule

// File: tb/tb_tile_turn_ctrl.sv
// Bench for tile_turn_ctrl: vector table, timing sequences and random picks
// against a pick-level game model, on a 4-tile board {3,7,3,7}.
module tb_tile_turn_ctrl;
    localparam int NT = 4, VW = 4, MW = 8, SC = 4, SETTLE = 12;

    logic CLOCK_50 = 1'b0, userquit_n = 1'b0, start = 1'b0;
    logic select1 = 1'b0, select2 = 1'b0;
    logic [NT-1:0] sw = '0;
    logic [NT-1:0] revealed, matched;
    logic [MW-1:0] moves;
    logic          bad_sel, busy, game_over;

    tile_turn_ctrl_if #(.NUM_TILES(NT), .VAL_W(VW)) rd_bus();

    tile_turn_ctrl #(.NUM_TILES(NT), .VAL_W(VW), .MOVE_W(MW), .SHOW_CYCLES(SC)) dut (
        .CLOCK_50(CLOCK_50), .userquit_n(userquit_n), .start(start),
        .select1(select1), .select2(select2), .sw(sw), .rd_bus(rd_bus),
        .revealed(revealed), .matched(matched), .moves(moves),
        .bad_sel(bad_sel), .busy(busy), .game_over(game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [VW-1:0] board [NT] = '{4'd3, 4'd7, 4'd3, 4'd7};
    int rd_cnt = 0;
    always @(posedge CLOCK_50) begin
        if (rd_bus.rd_en) begin
            rd_bus.rd_data <= board[rd_bus.rd_addr];
            rd_cnt <= rd_cnt + 1;
        end
    end

    int checks = 0, errors = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    typedef enum {OP_START, OP_SEL1, OP_SEL2, OP_BOTH} op_e;
    logic got_bad;

    // One stimulus event held for a single cycle, then enough idle cycles for
    // any read/compare/show sequence to finish.
    task automatic act(input op_e op, input logic [NT-1:0] swv);
        sw      = swv;
        start   = (op == OP_START);
        select1 = (op == OP_SEL1 || op == OP_BOTH);
        select2 = (op == OP_SEL2 || op == OP_BOTH);
        tick();
        got_bad = bad_sel;
        start = 1'b0; select1 = 1'b0; select2 = 1'b0;
        repeat (SETTLE) tick();
    endtask

    typedef struct {
        op_e           op;
        logic [NT-1:0] sw;
        logic          bad;
        logic [NT-1:0] rev;
        logic [NT-1:0] mat;
        int            mv;
        logic          over;
    } vec_t;
    vec_t tbl[$];

    // Game model: settled mode plus board sets, updated once per pick.
    typedef enum {M_IDLE, M_W1, M_W2, M_DONE} mmode_e;
    mmode_e        m_mode = M_IDLE;
    logic [NT-1:0] m_rev = '0, m_mat = '0;
    int            m_mv = 0, m_first = 0, m_rd = 0;
    logic          m_bad = 1'b0;

    task automatic model(input op_e op, input logic [NT-1:0] swv);
        int idx;
        bit ok;
        m_bad = 1'b0;
        if (op == OP_START) begin
            m_mode = M_W1; m_rev = '0; m_mat = '0; m_mv = 0;
            return;
        end
        idx = 0;
        for (int i = 0; i < NT; i++) if (swv[i]) idx = i;
        ok = ($countones(swv) == 1) && !m_mat[idx];
        if (m_mode == M_W1 && (op == OP_SEL1 || op == OP_BOTH)) begin
            if (ok) begin
                m_first = idx; m_rev[idx] = 1'b1; m_mode = M_W2; m_rd++;
            end else m_bad = 1'b1;
        end else if (m_mode == M_W2 && (op == OP_SEL2 || op == OP_BOTH)) begin
            if (ok && idx != m_first) begin
                m_rd++;
                if (m_mv < 255) m_mv++;
                m_rev = '0;
                if (board[idx] == board[m_first]) begin
                    m_mat[idx] = 1'b1; m_mat[m_first] = 1'b1;
                end
                m_mode = (&m_mat) ? M_DONE : M_W1;
            end else m_bad = 1'b1;
        end
    endtask

    initial begin
        int n, rd_base;
        op_e op;
        logic [NT-1:0] swv;

        // Reset state
        repeat (3) tick();
        check("rst revealed", revealed, 0);
        check("rst matched", matched, 0);
        check("rst moves", moves, 0);
        check("rst bad_sel", bad_sel, 0);
        check("rst busy", busy, 0);
        check("rst game_over", game_over, 0);
        check("rst rd_en", rd_bus.rd_en, 0);
        userquit_n = 1'b1;
        tick();

        //            op        sw       bad   rev      mat     mv  over
        tbl.push_back('{OP_SEL1,  4'b0001, 1'b0, 4'b0000, 4'b0000, 0, 1'b0}); // ignored in IDLE
        tbl.push_back('{OP_START, 4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 1'b0});
        tbl.push_back('{OP_SEL1,  4'b0011, 1'b1, 4'b0000, 4'b0000, 0, 1'b0}); // not one-hot
        tbl.push_back('{OP_SEL1,  4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 1'b0});
        tbl.push_back('{OP_SEL2,  4'b0001, 1'b0, 4'b0000, 4'b0000, 0, 1'b0}); // wrong key
        tbl.push_back('{OP_SEL1,  4'b0001, 1'b0, 4'b0001, 4'b0000, 0, 1'b0});
        tbl.push_back('{OP_SEL1,  4'b0010, 1'b0, 4'b0001, 4'b0000, 0, 1'b0}); // wrong key
        tbl.push_back('{OP_SEL2,  4'b0001, 1'b1, 4'b0001, 4'b0000, 0, 1'b0}); // same tile
        tbl.push_back('{OP_SEL2,  4'b0100, 1'b0, 4'b0000, 4'b0101, 1, 1'b0}); // 3==3
        tbl.push_back('{OP_SEL1,  4'b0100, 1'b1, 4'b0000, 4'b0101, 1, 1'b0}); // matched tile
        tbl.push_back('{OP_SEL1,  4'b0010, 1'b0, 4'b0010, 4'b0101, 1, 1'b0});
        tbl.push_back('{OP_SEL2,  4'b0001, 1'b1, 4'b0010, 4'b0101, 1, 1'b0}); // matched tile
        tbl.push_back('{OP_SEL2,  4'b1000, 1'b0, 4'b0000, 4'b1111, 2, 1'b1}); // game over
        tbl.push_back('{OP_SEL1,  4'b0001, 1'b0, 4'b0000, 4'b1111, 2, 1'b1}); // frozen
        tbl.push_back('{OP_START, 4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 1'b0});
        tbl.push_back('{OP_SEL1,  4'b0001, 1'b0, 4'b0001, 4'b0000, 0, 1'b0});
        tbl.push_back('{OP_SEL2,  4'b0010, 1'b0, 4'b0000, 4'b0000, 1, 1'b0}); // 3!=7
        foreach (tbl[i]) begin
            act(tbl[i].op, tbl[i].sw);
            check($sformatf("row%0d bad_sel", i), got_bad, tbl[i].bad);
            check($sformatf("row%0d revealed", i), revealed, tbl[i].rev);
            check($sformatf("row%0d matched", i), matched, tbl[i].mat);
            check($sformatf("row%0d moves", i), moves, tbl[i].mv);
            check($sformatf("row%0d game_over", i), game_over, tbl[i].over);
        end

        // Cycle-accurate pick, compare and show timing
        act(OP_START, '0);
        sw = 4'b0001; select1 = 1'b1; tick(); select1 = 1'b0;
        check("A1 rd_en", rd_bus.rd_en, 1);
        check("A1 rd_addr", rd_bus.rd_addr, 0);
        check("A1 busy", busy, 1);
        tick();
        check("A1 rd_en once", rd_bus.rd_en, 0);
        check("A1 rev early", revealed, 0);
        tick();
        check("A1 rev t+3", revealed, 4'b0001);
        repeat (2) tick();
        sw = 4'b0010; select2 = 1'b1; tick(); select2 = 1'b0;
        check("A2 rd_en", rd_bus.rd_en, 1);
        check("A2 rd_addr", rd_bus.rd_addr, 1);
        repeat (2) tick();
        check("A2 moves in CMP", moves, 0);
        tick();
        check("A2 moves after CMP", moves, 1);
        n = 0;
        while (revealed == 4'b0011 && n < 20) begin n++; tick(); end
        check("A show cycles", n, SC);
        check("A rev cleared", revealed, 0);
        check("A matched", matched, 0);
        check("A busy after show", busy, 0);

        // Asynchronous reset clears a finished game
        act(OP_START, '0);
        act(OP_SEL1, 4'b0001); act(OP_SEL2, 4'b0100);
        act(OP_SEL1, 4'b0010); act(OP_SEL2, 4'b1000);
        check("B game_over", game_over, 1);
        check("B moves", moves, 2);
        #2 userquit_n = 1'b0;
        #1;
        check("B rst matched", matched, 0);
        check("B rst game_over", game_over, 0);
        check("B rst moves", moves, 0);
        tick(); userquit_n = 1'b1; tick();

        // Reset during SHOW, then picks ignored until start
        act(OP_START, '0);
        act(OP_SEL1, 4'b0001);
        sw = 4'b0010; select2 = 1'b1; tick(); select2 = 1'b0;
        repeat (4) tick();
        check("C in show rev", revealed, 4'b0011);
        check("C in show busy", busy, 1);
        #2 userquit_n = 1'b0;
        #1;
        check("C rst revealed", revealed, 0);
        check("C rst moves", moves, 0);
        check("C rst busy", busy, 0);
        tick(); userquit_n = 1'b1; tick();
        n = rd_cnt;
        act(OP_SEL1, 4'b0001);
        check("C no-start bad", got_bad, 0);
        check("C no-start rev", revealed, 0);
        check("C no-start rd", rd_cnt, n);
        act(OP_START, '0);
        act(OP_SEL1, 4'b0001);
        check("C after start rev", revealed, 4'b0001);

        // Move counter saturation
        act(OP_START, '0);
        for (int i = 0; i < 255; i++) begin
            act(OP_SEL1, 4'b0001); act(OP_SEL2, 4'b0010);
        end
        check("D moves 255", moves, 255);
        act(OP_SEL1, 4'b0001); act(OP_SEL2, 4'b0010);
        check("D moves saturated", moves, 255);
        check("D rev", revealed, 0);

        // Random picks against the game model
        act(OP_START, '0);
        model(OP_START, '0);
        rd_base = rd_cnt;
        m_rd = 0;
        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(0, 99);
            op = (n < 4) ? OP_START : (n < 44) ? OP_SEL1 : (n < 84) ? OP_SEL2 : OP_BOTH;
            if ($urandom_range(0, 9) < 7) swv = NT'(1) << $urandom_range(0, NT - 1);
            else swv = NT'($urandom_range(0, 15));
            act(op, swv);
            model(op, swv);
            check($sformatf("R%0d bad_sel", i), got_bad, m_bad);
            check($sformatf("R%0d revealed", i), revealed, m_rev);
            check($sformatf("R%0d matched", i), matched, m_mat);
            check($sformatf("R%0d moves", i), moves, m_mv);
            check($sformatf("R%0d game_over", i), game_over, m_mode == M_DONE);
            check($sformatf("R%0d busy", i), busy, 0);
        end
        check("R rd_en pulses", rd_cnt - rd_base, m_rd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
